// File: rtl/mem_stage_pipe_pkg.sv
// mem_stage_pipe_pkg: shared FSM state type, funct3 load/store encodings and defaults for the memory stage.
package mem_stage_pipe_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-enable generation, store lane replication and load extraction/extension.
module mem_lane_align
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misaligned
);
  localparam int BW = XLEN / 8;
  logic [7:0]  b;
  logic [15:0] h;
  // funct3[1] selects word size, funct3[0] half, otherwise byte
  assign be = funct3[1] ? '1 : funct3[0] ? BW'(3) << {addr[1], 1'b0} : BW'(1) << addr;
  assign wdata_rep = funct3[1] ? wdata : funct3[0] ? {(XLEN/16){wdata[15:0]}} : {BW{wdata[7:0]}};
  assign misaligned = funct3[1] ? addr != 2'b00 : funct3[0] & addr[0];
  assign b = 8'(rdata >> {addr, 3'b000});
  assign h = 16'(rdata >> {addr[1], 4'b0000});
  assign rdata_ext = funct3 == F3_B  ? {{(XLEN-8){b[7]}}, b} :
                     funct3 == F3_H  ? {{(XLEN-16){h[15]}}, h} :
                     funct3 == F3_BU ? {{(XLEN-8){1'b0}}, b} :
                     funct3 == F3_HU ? {{(XLEN-16){1'b0}}, h} : rdata;
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory pipeline stage with a variable-latency bus handshake and writeback register.
// Define MEM_STAGE_PERF_EN to add saturating perf_mem_ops/perf_stall_cycles/perf_errors counters.
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_regwrite,
  input  logic              m_memread,
  input  logic              m_memwrite,
  input  logic [1:0]        m_resultsrc,
  input  logic [2:0]        m_funct3,
  input  logic [RD_W-1:0]   m_rd,
  input  logic [XLEN-1:0]   m_pc4,
  input  logic [XLEN-1:0]   m_alu,
  input  logic [XLEN-1:0]   m_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              w_valid,
  output logic              w_regwrite,
  output logic [1:0]        w_resultsrc,
  output logic [RD_W-1:0]   w_rd,
  output logic [XLEN-1:0]   w_pc4,
  output logic [XLEN-1:0]   w_alu,
  output logic [XLEN-1:0]   w_rdata,
  output logic              stall,
  output logic              mem_error,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0]       perf_mem_ops,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_errors,
`endif
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_funct3;
  logic              op_regwrite;
  logic [1:0]        op_resultsrc;
  logic [RD_W-1:0]   op_rd;
  logic [XLEN-1:0]   op_pc4, op_alu;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata_rep, rdata_ext;
  logic              misaligned, xfer, is_mem, tmo;
  assign m_ready = state == IDLE;
  assign stall   = state == ACCESS;
  assign xfer    = m_valid & m_ready;
  assign is_mem  = m_memread | m_memwrite;
  assign tmo     = stall & ~mem_ack & (cnt == CW'(TIMEOUT - 1));
  // IDLE aligns the incoming op; afterwards the captured op drives load extraction
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3    (m_ready ? m_funct3 : op_funct3),
    .addr      (m_ready ? m_alu[1:0] : op_alu[1:0]),
    .wdata     (m_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misaligned(misaligned)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      {op_funct3, op_regwrite, op_resultsrc, op_rd, op_pc4, op_alu} <= '0;
      {mem_req, mem_we, mem_be, mem_addr, mem_wdata} <= '0;
      {w_valid, w_regwrite, w_resultsrc, w_rd, w_pc4, w_alu, w_rdata} <= '0;
      mem_error <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      mem_error <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          if (!is_mem || misaligned) begin
            w_valid <= 1'b1;
            w_regwrite <= m_regwrite & ~is_mem;
            w_resultsrc <= m_resultsrc;
            w_rd <= m_rd;
            w_pc4 <= m_pc4;
            w_alu <= m_alu;
            mem_error <= is_mem;
            state <= is_mem ? DONE : IDLE;
          end else begin
            {op_funct3, op_regwrite, op_resultsrc, op_rd, op_pc4, op_alu} <=
              {m_funct3, m_regwrite, m_resultsrc, m_rd, m_pc4, m_alu};
            {mem_req, mem_we, mem_be, mem_addr, mem_wdata} <= {1'b1, m_memwrite, be, m_alu, wdata_rep};
            cnt <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: if (mem_ack || tmo) begin
          mem_req <= 1'b0;
          w_valid <= 1'b1;
          w_regwrite <= op_regwrite & mem_ack & ~mem_err;
          w_resultsrc <= op_resultsrc;
          w_rd <= op_rd;
          w_pc4 <= op_pc4;
          w_alu <= op_alu;
          w_rdata <= mem_ack ? rdata_ext : w_rdata;
          mem_error <= mem_ack & mem_err;
          timeout_err <= ~mem_ack;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_mem_ops <= '0;
      perf_stall_cycles <= '0;
      perf_errors <= '0;
    end else begin
      if (stall && mem_ack && ~&perf_mem_ops) perf_mem_ops <= perf_mem_ops + 1'b1;
      if (stall && ~&perf_stall_cycles) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if ((mem_error || timeout_err) && ~&perf_errors) perf_errors <= perf_errors + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: scoreboard bench; the driver queues expected writebacks, a negedge monitor retires them.
module tb_mem_stage_pipe;
  localparam int TO = 8;
  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc4, alu, rdata;
    logic        me, te;
  } exp_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic m_valid = 0, m_regwrite = 0, m_memread = 0, m_memwrite = 0;
  logic [1:0] m_resultsrc = '0;
  logic [2:0] m_funct3 = '0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_pc4 = '0, m_alu = '0, m_wdata = '0;
  logic mem_ack = 0, mem_err = 0;
  logic [31:0] mem_rdata = '0;
  logic m_ready, mem_req, mem_we, w_valid, w_regwrite, stall, mem_error, timeout_err;
  logic [31:0] mem_addr, mem_wdata, w_pc4, w_alu, w_rdata;
  logic [3:0] mem_be;
  logic [1:0] w_resultsrc;
  logic [4:0] w_rd;
  exp_t q[$];
  exp_t got;
  logic [31:0] last_rdata = '0;
  int vecs = 0, errs = 0;

  mem_stage_pipe #(.XLEN(32), .RD_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
    .m_regwrite(m_regwrite), .m_memread(m_memread), .m_memwrite(m_memwrite),
    .m_resultsrc(m_resultsrc), .m_funct3(m_funct3), .m_rd(m_rd),
    .m_pc4(m_pc4), .m_alu(m_alu), .m_wdata(m_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_regwrite(w_regwrite), .w_resultsrc(w_resultsrc), .w_rd(w_rd),
    .w_pc4(w_pc4), .w_alu(w_alu), .w_rdata(w_rdata),
    .stall(stall), .mem_error(mem_error), .timeout_err(timeout_err)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sz(logic [2:0] f3);
    return f3[1] ? 4 : f3[0] ? 2 : 1;
  endfunction

  function automatic logic [3:0] be_ref(logic [2:0] f3, logic [31:0] a);
    return 4'(((1 << sz(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wd_ref(logic [2:0] f3, logic [31:0] wd);
    return sz(f3) == 4 ? wd : sz(f3) == 2 ? (wd & 32'hFFFF) * 32'h00010001 : (wd & 32'hFF) * 32'h01010101;
  endfunction

  function automatic logic [31:0] ld_ref(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return b >= 128 ? b - 32'd256 : b;
      3'b001:  return h >= 32768 ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // dly = ACCESS cycle index carrying the ack; dly >= TO means the bus never answers
  task automatic do_op(input logic rw, input logic mr, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic [31:0] wd, input int dly,
                       input logic err, input logic [31:0] rdat);
    exp_t e;
    int n;
    logic mem, mis, ok_ack;
    mem = mr | mw;
    mis = mem && (alu % sz(f3)) != 0;
    ok_ack = mem && !mis && dly < TO;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("m_ready_wait", m_ready, 1);
    {m_regwrite, m_memread, m_memwrite, m_resultsrc, m_funct3, m_rd, m_pc4, m_alu, m_wdata} =
      {rw, mr, mw, rs, f3, rd, pc4, alu, wd};
    m_valid = 1;
    e.rw = rw && (!mem || (ok_ack && !err));
    e.rs = rs;
    e.rd = rd;
    e.pc4 = pc4;
    e.alu = alu;
    e.me = mis || (ok_ack && err);
    e.te = mem && !mis && dly >= TO;
    if (ok_ack) last_rdata = ld_ref(f3, alu, rdat);
    e.rdata = last_rdata;
    q.push_back(e);
    @(negedge clk);
    m_valid = 0;
    if (!mem || mis) chk("no_mem_req", mem_req, 0);
    else begin
      for (int k = 0; k < TO; k++) begin
        chk("stall", stall, 1);
        chk("m_ready_busy", m_ready, 0);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, mw);
        chk("mem_addr", mem_addr, alu);
        chk("mem_be", mem_be, be_ref(f3, alu));
        if (mw) chk("mem_wdata", mem_wdata, wd_ref(f3, wd));
        mem_rdata = (k == dly) ? rdat : $urandom;
        mem_ack = (k == dly);
        mem_err = (k == dly) && err;
        @(negedge clk);
        mem_ack = 0;
        mem_err = 0;
        if (k == dly) break;
      end
      chk("stall_done", stall, 0);
      chk("mem_req_done", mem_req, 0);
    end
  endtask

  always @(negedge clk) if (rst) begin
    if (w_valid && q.size() > 0) begin
      got = q.pop_front();
      chk("w_regwrite", w_regwrite, got.rw);
      chk("w_resultsrc", w_resultsrc, got.rs);
      chk("w_rd", w_rd, got.rd);
      chk("w_pc4", w_pc4, got.pc4);
      chk("w_alu", w_alu, got.alu);
      chk("w_rdata", w_rdata, got.rdata);
      chk("mem_error", mem_error, got.me);
      chk("timeout_err", timeout_err, got.te);
    end else if (w_valid) chk("spurious_w_valid", w_valid, 0);
    else chk("stray_err_pulse", {mem_error, timeout_err}, 0);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_ready"}, m_ready, 1);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we_be"}, {mem_we, mem_be}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_w_ctl"}, {w_valid, w_regwrite, w_resultsrc, w_rd}, 0);
    chk({tag, "_w_pc4"}, w_pc4, 0);
    chk({tag, "_w_alu"}, w_alu, 0);
    chk({tag, "_w_rdata"}, w_rdata, 0);
    chk({tag, "_flags"}, {stall, mem_error, timeout_err}, 0);
  endtask

  initial begin
    logic [2:0] lf [5];
    logic [2:0] f3;
    lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1;
    @(negedge clk);
    do_op(1, 0, 0, 2'd0, 3'd0, 5'd5, 32'h104, 32'h1234, 32'h0, 0, 0, 32'h0);
    do_op(1, 1, 0, 2'd1, 3'b000, 5'd6, 32'h108, 32'h103, 32'h0, 2, 0, 32'h80FFFFFF);
    do_op(0, 0, 1, 2'd0, 3'b001, 5'd0, 32'h10C, 32'h202, 32'h0000ABCD, 0, 0, 32'h0);
    do_op(1, 1, 0, 2'd1, 3'b010, 5'd7, 32'h110, 32'h101, 32'h0, 0, 0, 32'h0);
    do_op(1, 1, 0, 2'd1, 3'b010, 5'd8, 32'h114, 32'h300, 32'h0, 99, 0, 32'h12345678);
    do_op(1, 1, 0, 2'd1, 3'b010, 5'd9, 32'h118, 32'h304, 32'h0, TO - 1, 0, 32'hCAFEF00D);
    do_op(1, 1, 0, 2'd1, 3'b101, 5'd10, 32'h11C, 32'h306, 32'h0, 1, 1, 32'h8765_4321);
    do_op(1, 1, 0, 2'd1, 3'b100, 5'd11, 32'h120, 32'h301, 32'h0, 0, 0, 32'h0000_9A00);
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      f3 = kind == 1 ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      do_op(kind == 2 ? 1'b0 : 1'($urandom), kind == 1, kind == 2, 2'($urandom), f3,
            5'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 9),
            $urandom_range(0, 7) == 0, $urandom);
    end
    // abort a word load mid-ACCESS with an asynchronous reset
    repeat (2) @(negedge clk);
    {m_regwrite, m_memread, m_memwrite, m_funct3, m_rd, m_alu} = {1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h400};
    m_valid = 1;
    @(negedge clk);
    m_valid = 0;
    chk("pre_reset_req", mem_req, 1);
    #2 rst = 0;
    #1 chk_reset_outputs("mid_access_reset");
    @(negedge clk);
    rst = 1;
    last_rdata = '0;
    @(negedge clk);
    do_op(1, 1, 0, 2'd1, 3'b010, 5'd12, 32'h124, 32'h500, 32'h0, 1, 0, 32'h55AA_33CC);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, data/address width; RD_W, 5, register index width; TIMEOUT, 255, max cycles waiting for mem_ack.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 m_valid/m_ready  in/out  1/1  handshake with the execute stage; transfer when both are high.
REQ-005 m_regwrite, m_memread, m_memwrite  in  1 each  instruction controls.
REQ-006 m_resultsrc  in  2;  m_funct3  in  3 (load/store size and sign);  m_rd  in  RD_W.
REQ-007 m_pc4, m_alu, m_wdata  in  XLEN each  PC+4, address/ALU result, store data.
REQ-008 mem_req, mem_we  out  1/1;  mem_addr, mem_wdata  out  XLEN;  mem_be  out  XLEN/8.
REQ-009 mem_ack, mem_err  in  1/1;  mem_rdata  in  XLEN  variable-latency memory response.
REQ-010 w_valid, w_regwrite  out  1/1;  w_resultsrc  out  2;  w_rd  out  RD_W;  w_pc4, w_alu, w_rdata  out  XLEN.
REQ-011 stall  out  1;  mem_error  out  1 (single-cycle pulse);  timeout_err  out  1 (single-cycle pulse).

Function
REQ-012 FSM states: IDLE, ACCESS, DONE.
REQ-013 IDLE: m_ready=1. On a transfer with memread|memwrite, capture all inputs and go to ACCESS. On a transfer without a memory operation, load the writeback register on the next edge with w_valid=1.
REQ-014 ACCESS: mem_req=1, and address, data, byte-enables and mem_we stay stable until mem_ack. m_ready=0 and stall=1.
REQ-015 ACCESS with mem_ack=1: latch extracted load data, go to DONE, and count the transaction.
REQ-016 DONE: drive the writeback register with w_valid=1 for exactly one cycle, then return to IDLE with m_ready=1. Minimum memory-op latency is 2 cycles from m_valid to w_valid.
REQ-017 Byte enables from funct3[1:0] and addr[1:0]: byte gives 1<<addr[1:0]; half gives 0011<<addr[1]*2; word gives all ones. Store data is replicated into the lanes.
REQ-018 Load extraction: funct3 = 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend. Any other code gives the raw word.
REQ-019 A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) issues no mem_req. It pulses mem_error, produces writeback with w_regwrite forced to 0, and takes the DONE path.
REQ-020 mem_err together with mem_ack pulses mem_error and forces w_regwrite=0.
REQ-021 The wait counter resets on entry to ACCESS. When the count reaches TIMEOUT without an ack: pulse timeout_err, drop mem_req, force w_regwrite=0, go to DONE. A mem_ack arriving in the same cycle as the timeout takes priority.
REQ-022 w_valid=0 in every cycle with no retirement. w_* data holds its last value.
REQ-023 When m_valid=0, IDLE holds and no outputs toggle except the w_valid drop.

Reset
REQ-024 An asserted rst in any state, including mid-ACCESS, clears the following immediately:
- state returns to IDLE; mem_req=0, mem_we=0, mem_be=0;
- w_valid=0, w_regwrite=0, w_resultsrc=0, w_rd=0;
- all XLEN outputs = 0;
- stall=0, mem_error=0, timeout_err=0; counters=0.
REQ-025 m_ready=1 during and after reset.

Configuration
REQ-026 Macro MEM_STAGE_PERF_EN enables 32-bit saturating counters perf_mem_ops, perf_stall_cycles and perf_errors, each an output port.
REQ-027 Without MEM_STAGE_PERF_EN the ports and counters are absent, and all other behaviour is identical.

Structure
REQ-028 A shared package holds:
- the FSM state enum;
- funct3 load/store encodings;
- the TIMEOUT default.
REQ-029 A single sub-module, mem_lane_align, is combinational and performs byte-enable generation, store replication and load extraction/extension.

Verification
REQ-030 ALU op: m_alu=0x1234, m_rd=5, m_regwrite=1 -> next cycle w_valid=1, w_alu=0x1234, no mem_req.
REQ-031 LB at address 0x103 with mem_rdata=0x80FFFFFF and ack after 3 cycles -> stall=1 for 3 cycles, then w_rdata=0xFFFFFF80, w_valid for 1 cycle.
REQ-032 SH at address 0x202 with m_wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, w_regwrite=0.
REQ-033 LW at address 0x101 -> mem_error pulse, no mem_req, w_regwrite=0.
REQ-034 No ack with TIMEOUT=8 -> timeout_err after 8 ACCESS cycles, then IDLE; a second run with ack on cycle 8 gives a normal completion.
REQ-035 rst asserted mid-ACCESS -> mem_req drops asynchronously, all outputs are 0, and the next op completes normally.
